// File: rtl/dma_dispatch_if.sv
// rtl/dma_dispatch_if.sv - signal bundle between command processor, dma_dispatch and the dma engine
//
// Purpose: groups the descriptor push, DMA start/done and completion
// handshakes of dma_dispatch into one bus.
// Ports (slave = dma_dispatch side):
//   cmd_valid/cmd_ready, cmd_src/dst/len/tag, cmd_src_res/cmd_dst_res : descriptor push
//   dma_start, dma_src_addr/dst_addr/len, dma_src/dst_resident, dma_done : DMA engine
//   cpl_valid/cpl_ready, cpl_tag, cpl_status                           : completion return
//   fifo_count, busy                                                   : status
interface dma_dispatch_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [63:0]      cmd_src;
  logic [63:0]      cmd_dst;
  logic [31:0]      cmd_len;
  logic [TAG_W-1:0] cmd_tag;
  logic             cmd_src_res;
  logic             cmd_dst_res;

  logic             dma_start;
  logic [63:0]      dma_src_addr;
  logic [63:0]      dma_dst_addr;
  logic [31:0]      dma_len;
  logic             dma_src_resident;
  logic             dma_dst_resident;
  logic             dma_done;

  logic             cpl_valid;
  logic             cpl_ready;
  logic [TAG_W-1:0] cpl_tag;
  logic [1:0]       cpl_status;

  logic [CNT_W-1:0] fifo_count;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_tag, cmd_src_res, cmd_dst_res,
    output cmd_ready,
    output dma_start, dma_src_addr, dma_dst_addr, dma_len, dma_src_resident, dma_dst_resident,
    input  dma_done,
    output cpl_valid, cpl_tag, cpl_status,
    input  cpl_ready,
    output fifo_count, busy
  );

  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_tag, cmd_src_res, cmd_dst_res,
    input  cmd_ready,
    input  dma_start, dma_src_addr, dma_dst_addr, dma_len, dma_src_resident, dma_dst_resident,
    output dma_done,
    input  cpl_valid, cpl_tag, cpl_status,
    output cpl_ready,
    input  fifo_count, busy
  );
endinterface

// File: rtl/dma_dispatch.sv
// rtl/dma_dispatch.sv - descriptor FIFO and one-at-a-time issue/complete front end for the dma engine
//
// Purpose: buffers descriptors, issues resident ones to the DMA with a
// one-cycle start pulse, waits for done (or watchdog timeout) and returns
// one tagged completion per descriptor, in order. Non-resident descriptors
// complete with FAULT without touching the engine.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : dma_dispatch_if.slave (cmd push, dma start/done, cpl return, status)
module dma_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1048576
) (
  input  logic          clk,
  input  logic          rst_n,
  dma_dispatch_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_CPL   = 2'd3;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_FAULT   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT - 1);

  logic [63:0]      r_fifo_src  [DEPTH];
  logic [63:0]      r_fifo_dst  [DEPTH];
  logic [31:0]      r_fifo_len  [DEPTH];
  logic [TAG_W-1:0] r_fifo_tag  [DEPTH];
  logic             r_fifo_sres [DEPTH];
  logic             r_fifo_dres [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [1:0]       r_state;
  logic [31:0]      r_timer;
  logic [63:0]      r_dma_src;
  logic [63:0]      r_dma_dst;
  logic [31:0]      r_dma_len;
  logic             r_dma_sres;
  logic             r_dma_dres;
  logic [TAG_W-1:0] r_cpl_tag;
  logic [1:0]       r_cpl_status;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_head_res;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_push     = bus.cmd_valid && !w_full;
  // Popping only from IDLE keeps the engine strictly one descriptor at a time.
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_head_res = r_fifo_sres[r_rd_ptr] && r_fifo_dres[r_rd_ptr];

  // Entry storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_src[r_wr_ptr]  <= bus.cmd_src;
      r_fifo_dst[r_wr_ptr]  <= bus.cmd_dst;
      r_fifo_len[r_wr_ptr]  <= bus.cmd_len;
      r_fifo_tag[r_wr_ptr]  <= bus.cmd_tag;
      r_fifo_sres[r_wr_ptr] <= bus.cmd_src_res;
      r_fifo_dres[r_wr_ptr] <= bus.cmd_dst_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_dma_src    <= '0;
      r_dma_dst    <= '0;
      r_dma_len    <= '0;
      r_dma_sres   <= 1'b0;
      r_dma_dres   <= 1'b0;
      r_cpl_tag    <= '0;
      r_cpl_status <= ST_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            // Engine-facing fields are only rewritten here, so they stay
            // stable for the whole transfer.
            r_dma_src  <= r_fifo_src[r_rd_ptr];
            r_dma_dst  <= r_fifo_dst[r_rd_ptr];
            r_dma_len  <= r_fifo_len[r_rd_ptr];
            r_dma_sres <= r_fifo_sres[r_rd_ptr];
            r_dma_dres <= r_fifo_dres[r_rd_ptr];
            r_cpl_tag  <= r_fifo_tag[r_rd_ptr];
            if (w_head_res) begin
              r_state <= S_ISSUE;
            end else begin
              r_cpl_status <= ST_FAULT;
              r_state      <= S_CPL;
            end
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // done is checked first so a done on the last watchdog cycle wins.
          if (bus.dma_done) begin
            r_cpl_status <= ST_OK;
            r_state      <= S_CPL;
          end else if (r_timer == TIMER_LAST) begin
            r_cpl_status <= ST_TIMEOUT;
            r_state      <= S_CPL;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        S_CPL: begin
          if (bus.cpl_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready        = !w_full;
  assign bus.dma_start        = (r_state == S_ISSUE);
  assign bus.dma_src_addr     = r_dma_src;
  assign bus.dma_dst_addr     = r_dma_dst;
  assign bus.dma_len          = r_dma_len;
  assign bus.dma_src_resident = r_dma_sres;
  assign bus.dma_dst_resident = r_dma_dres;
  assign bus.cpl_valid        = (r_state == S_CPL);
  assign bus.cpl_tag          = r_cpl_tag;
  assign bus.cpl_status       = r_cpl_status;
  assign bus.fifo_count       = r_count;
  assign bus.busy             = (r_state != S_IDLE) || (r_count != '0);
endmodule

// File: tb/tb_dma_dispatch.sv
// tb/tb_dma_dispatch.sv - table-driven and randomized self-checking bench for dma_dispatch
module tb_dma_dispatch;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int N_RAND  = 150;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_dispatch_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  dma_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] len;
    logic [3:0]  tag;
    logic        sres;
    logic        dres;
  } desc_t;

  typedef struct {
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] len;
    logic [3:0]  tag;
    logic        sres;
    logic        dres;
    int          done_at;     // cycles into WAIT when done is driven; 0 = never
    logic        exp_start;
    logic [1:0]  exp_status;
    int          exp_cpl_j;   // loop index at which cpl_valid first shows
  } vec_t;

  vec_t tbl [8];

  // DMA stub: manual done for directed tests, latency-based done otherwise.
  logic man_done  = 1'b0;
  logic auto_done = 1'b0;
  logic stub_en   = 1'b0;
  int   stub_fix  = -1;
  int   stub_cnt  = 0;
  int   last_d    = 0;
  assign bus.dma_done = stub_en ? auto_done : man_done;

  logic  mon_on = 1'b0;
  logic  hs_cmd = 1'b0;
  desc_t q_all[$];
  desc_t q_iss[$];
  int    n_cpl = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event not expected by the model", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst_vals(input string p);
    check({p, "_cmd_ready"},  bus.cmd_ready, 1);
    check({p, "_dma_start"},  bus.dma_start, 0);
    check({p, "_dma_src"},    bus.dma_src_addr, 0);
    check({p, "_dma_dst"},    bus.dma_dst_addr, 0);
    check({p, "_dma_len"},    bus.dma_len, 0);
    check({p, "_dma_sres"},   bus.dma_src_resident, 0);
    check({p, "_dma_dres"},   bus.dma_dst_resident, 0);
    check({p, "_cpl_valid"},  bus.cpl_valid, 0);
    check({p, "_cpl_tag"},    bus.cpl_tag, 0);
    check({p, "_cpl_status"}, bus.cpl_status, 0);
    check({p, "_fifo_count"}, bus.fifo_count, 0);
    check({p, "_busy"},       bus.busy, 0);
  endtask

  task automatic drive_cmd(input desc_t d);
    bus.cmd_src     = d.src;
    bus.cmd_dst     = d.dst;
    bus.cmd_len     = d.len;
    bus.cmd_tag     = d.tag;
    bus.cmd_src_res = d.sres;
    bus.cmd_dst_res = d.dres;
  endtask

  // Directed vector: push one descriptor into an idle, empty dispatcher.
  task automatic run_vec(input vec_t v);
    desc_t d;
    int    first_j;
    logic  extra_start;
    logic  held;
    d = '{v.src, v.dst, v.len, v.tag, v.sres, v.dres};
    drive_cmd(d);
    bus.cmd_valid = 1'b1;
    check("vec_cmd_ready", bus.cmd_ready, 1);
    tick();                                   // accept edge N
    bus.cmd_valid = 1'b0;
    check("vec_start_at_accept", bus.dma_start, 0);
    tick();                                   // pop edge N+1
    check("vec_start", bus.dma_start, v.exp_start);
    if (v.exp_start) begin
      check("vec_dma_src",  bus.dma_src_addr, v.src);
      check("vec_dma_dst",  bus.dma_dst_addr, v.dst);
      check("vec_dma_len",  bus.dma_len, v.len);
      check("vec_dma_sres", bus.dma_src_resident, v.sres);
      check("vec_dma_dres", bus.dma_dst_resident, v.dres);
      first_j     = 0;
      extra_start = 1'b0;
      held        = 1'b1;
      for (int j = 1; j <= 22; j++) begin
        tick();
        if (bus.dma_start) extra_start = 1'b1;
        if (bus.dma_src_addr !== v.src || bus.dma_len !== v.len) held = 1'b0;
        if (bus.cpl_valid && first_j == 0) first_j = j;
        man_done = (j == v.done_at);
      end
      man_done = 1'b0;
      check("vec_cpl_latency", 64'(first_j), 64'(v.exp_cpl_j));
      check("vec_single_start", extra_start, 0);
      check("vec_dma_held", held, 1);
    end else begin
      tick();
    end
    check("vec_cpl_valid_held", bus.cpl_valid, 1);
    check("vec_cpl_tag", bus.cpl_tag, v.tag);
    check("vec_cpl_status", bus.cpl_status, v.exp_status);
    bus.cpl_ready = 1'b1;
    tick();
    bus.cpl_ready = 1'b0;
    check("vec_cpl_drop", bus.cpl_valid, 0);
    check("vec_idle_busy", bus.busy, 0);
  endtask

  always @(negedge clk) begin
    auto_done = 1'b0;
    if (!rst_n) begin
      stub_cnt = 0;
    end else if (bus.dma_start) begin
      if (stub_fix >= 0) stub_cnt = stub_fix;
      else stub_cnt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 16));
      last_d = stub_cnt;
    end else if (stub_cnt != 0) begin
      if (stub_cnt == 1) auto_done = 1'b1;
      stub_cnt--;
    end
  end

  // Reference model: descriptors complete in push order; a non-resident one
  // is FAULT, a resident one is OK iff the engine answered within TIMEOUT
  // WAIT cycles, else TIMEOUT. Only resident ones may be started, in order.
  always @(negedge clk) begin
    desc_t      d;
    desc_t      e;
    logic [1:0] exp_st;
    hs_cmd = bus.cmd_valid && bus.cmd_ready;
    if (mon_on && rst_n) begin
      if (hs_cmd) begin
        d = '{bus.cmd_src, bus.cmd_dst, bus.cmd_len, bus.cmd_tag, bus.cmd_src_res, bus.cmd_dst_res};
        q_all.push_back(d);
        if (d.sres && d.dres) q_iss.push_back(d);
      end
      if (bus.dma_start) begin
        if (q_iss.size() == 0) begin
          fail_now("mdl_start_unexpected");
        end else begin
          e = q_iss.pop_front();
          check("mdl_start_src", bus.dma_src_addr, e.src);
          check("mdl_start_dst", bus.dma_dst_addr, e.dst);
          check("mdl_start_len", bus.dma_len, e.len);
        end
      end
      if (bus.cpl_valid && bus.cpl_ready) begin
        n_cpl++;
        if (q_all.size() == 0) begin
          fail_now("mdl_cpl_unexpected");
        end else begin
          e = q_all.pop_front();
          if (!(e.sres && e.dres)) exp_st = 2'b01;
          else if (last_d >= 1 && last_d <= TIMEOUT) exp_st = 2'b00;
          else exp_st = 2'b10;
          check("mdl_cpl_tag", bus.cpl_tag, e.tag);
          check("mdl_cpl_status", bus.cpl_status, exp_st);
        end
      end
    end
  end

  initial begin
    desc_t d;
    int    n_sent;
    int    bound;

    tbl[0] = '{64'h1000, 64'h2000, 32'd5, 4'd3, 1'b1, 1'b1, 5, 1'b1, 2'b00, 6};
    tbl[1] = '{64'hA0, 64'hB0, 32'd8, 4'd7, 1'b1, 1'b0, 0, 1'b0, 2'b01, 0};
    tbl[2] = '{64'hC0, 64'hD0, 32'd9, 4'd2, 1'b0, 1'b1, 0, 1'b0, 2'b01, 0};
    tbl[3] = '{64'h3000, 64'h4000, 32'd0, 4'd5, 1'b1, 1'b1, 1, 1'b1, 2'b00, 2};
    tbl[4] = '{64'h5000, 64'h6000, 32'd11, 4'd9, 1'b1, 1'b1, 16, 1'b1, 2'b00, 17};
    tbl[5] = '{64'h7000, 64'h8000, 32'd12, 4'hC, 1'b1, 1'b1, 0, 1'b1, 2'b10, 17};
    tbl[6] = '{64'h9000, 64'hA000, 32'd3, 4'hE, 1'b1, 1'b1, 17, 1'b1, 2'b10, 17};
    tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 3, 1'b1, 2'b00, 4};

    bus.cmd_valid = 1'b0;
    bus.cpl_ready = 1'b0;
    d = '{64'h0, 64'h0, 32'h0, 4'h0, 1'b0, 1'b0};
    drive_cmd(d);

    tick();
    check_rst_vals("rst_hold");
    tick();
    rst_n = 1'b1;
    tick();
    check_rst_vals("rst_rel");

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Late done after the timed-out vector, arriving in IDLE.
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    check("late_done_busy", bus.busy, 0);
    check("late_done_cpl", bus.cpl_valid, 0);
    check("late_done_start", bus.dma_start, 0);

    // Fill: tag 0 in flight, tags 1..4 fill the FIFO, a 6th push is refused.
    mon_on   = 1'b1;
    stub_en  = 1'b1;
    stub_fix = 12;
    for (int t = 0; t < 5; t++) begin
      d = '{64'(t * 256 + 64'h10000), 64'(t * 256 + 64'h20000), 32'(t + 4), 4'(t), 1'b1, 1'b1};
      drive_cmd(d);
      bus.cmd_valid = 1'b1;
      tick();
    end
    check("fill_count", bus.fifo_count, 4);
    check("fill_cmd_ready", bus.cmd_ready, 0);
    d = '{64'hDEAD, 64'hBEEF, 32'd1, 4'd9, 1'b1, 1'b1};
    drive_cmd(d);
    tick();
    tick();
    bus.cmd_valid = 1'b0;
    check("fill_no_push_full", bus.fifo_count, 4);
    bound = 0;
    while (!bus.cpl_valid && bound < 40) begin
      tick();
      bound++;
    end
    check("fill_first_cpl_seen", bus.cpl_valid, 1);
    bus.cpl_ready = 1'b1;
    bound = 0;
    while (q_all.size() != 0 && bound < 300) begin
      tick();
      bound++;
    end
    check("fill_drained", 64'(q_all.size()), 0);
    check("fill_cpl_count", 64'(n_cpl), 5);
    bus.cpl_ready = 1'b0;

    // Randomized traffic against the model.
    stub_fix = -1;
    n_cpl    = 0;
    n_sent   = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      if (hs_cmd) begin
        n_sent++;
        bus.cmd_valid = 1'b0;
      end
      if (!bus.cmd_valid && n_sent < N_RAND && $urandom_range(0, 2) != 0) begin
        d.src  = {$urandom, $urandom};
        d.dst  = {$urandom, $urandom};
        d.len  = 32'($urandom_range(0, 64));
        d.tag  = 4'($urandom_range(0, 15));
        d.sres = ($urandom_range(0, 5) != 0);
        d.dres = ($urandom_range(0, 5) != 0);
        drive_cmd(d);
        bus.cmd_valid = 1'b1;
      end
      bus.cpl_ready = ($urandom_range(0, 3) != 0);
      if (n_sent == N_RAND && !bus.cmd_valid && q_all.size() == 0) break;
    end
    bus.cpl_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    check("rand_sent", 64'(n_sent), 64'(N_RAND));
    check("rand_drained", 64'(q_all.size()), 0);
    check("rand_cpl_count", 64'(n_cpl), 64'(N_RAND));
    tick();
    mon_on  = 1'b0;
    stub_en = 1'b0;

    // Reset during WAIT with two descriptors queued.
    for (int t = 1; t <= 3; t++) begin
      d = '{64'(t * 16), 64'(t * 32), 32'(t), 4'(t), 1'b1, 1'b1};
      drive_cmd(d);
      bus.cmd_valid = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    tick();
    check("rstw_queued", bus.fifo_count, 2);
    check("rstw_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_rst_vals("rstw_async");
    tick();
    tick();
    rst_n = 1'b1;
    bus.cpl_ready = 1'b1;
    bound = 0;
    for (int j = 0; j < 25; j++) begin
      tick();
      if (bus.cpl_valid || bus.dma_start) bound++;
    end
    bus.cpl_ready = 1'b0;
    check("rstw_no_cpl_after", 64'(bound), 0);
    check("rstw_count", bus.fifo_count, 0);
    check("rstw_idle", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
